// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scanner
// Brief    : Multiplexed BCD display scanner with guard interval, frame-
//            synchronous double buffering and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  lzb_en,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done,
    output logic                  load_ack
);

    localparam int C_CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int C_CW      = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
    localparam int C_IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [C_CW-1:0] C_SHOW_LAST  = C_CW'(SCAN_DIV - 1);
    localparam logic [C_CW-1:0] C_GUARD_LAST = C_CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [C_CW-1:0] C_CNT_ONE    = C_CW'(1);
    localparam logic [C_IW-1:0] C_IDX_LAST   = C_IW'(DIGITS - 1);
    localparam logic [C_IW-1:0] C_IDX_ONE    = C_IW'(1);

    localparam logic [0:0] S_GUARD = 1'b0;
    localparam logic [0:0] S_SHOW  = 1'b1;
    // Phase entered at reset and after every digit; skips GUARD when it is zero.
    localparam logic [0:0] C_PHASE_ENTRY = (GUARD > 0) ? S_GUARD : S_SHOW;

    logic [0:0]          r_phase, w_phase_nxt;
    logic [C_CW-1:0]     r_cnt, w_cnt_nxt;
    logic [C_IW-1:0]     r_idx, w_idx_nxt;
    logic                w_advance, w_boundary;

    logic [4*DIGITS-1:0] r_active, r_pending, w_active_nxt;
    logic                r_pending_vld, r_code_vld, r_blank;

    logic [3:0]          w_digit, w_bcd_nxt;
    logic                w_zero_run, w_zero_above;
    logic                w_upd, w_blank_calc, w_blank_nxt;
    logic [DIGITS-1:0]   w_an_nxt;
    logic                w_fd_nxt, w_ack_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= C_PHASE_ENTRY;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_advance   = (r_phase == S_SHOW) && (r_cnt == C_SHOW_LAST);
        w_boundary  = w_advance && (r_idx == C_IDX_LAST);
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + C_CNT_ONE;
        w_idx_nxt   = r_idx;
        case (r_phase)
            S_GUARD: begin
                if (r_cnt == C_GUARD_LAST) begin
                    w_phase_nxt = S_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            S_SHOW: begin
                if (w_advance) begin
                    w_phase_nxt = C_PHASE_ENTRY;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == C_IDX_LAST) ? '0 : r_idx + C_IDX_ONE;
                end
            end
            default: begin
                w_phase_nxt = C_PHASE_ENTRY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        w_active_nxt = r_active;
        if (w_boundary) begin
            if (load) begin
                w_active_nxt = bcd_in;
            end else if (r_pending_vld) begin
                w_active_nxt = r_pending;
            end
        end

        // Walk from the top digit down so the zero run covers idx..DIGITS-1.
        w_digit      = 4'h0;
        w_zero_above = 1'b0;
        w_zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (w_active_nxt[4*i +: 4] == 4'h0);
            if (w_idx_nxt == C_IW'(i)) begin
                w_digit      = w_active_nxt[4*i +: 4];
                w_zero_above = w_zero_run;
            end
        end

        // Digit code (and blanking) is latched only when a new digit is taken up.
        w_upd        = w_advance || !r_code_vld;
        w_blank_calc = lzb_en && (w_idx_nxt != '0) && w_zero_above;
        w_blank_nxt  = w_upd ? w_blank_calc : r_blank;
        w_bcd_nxt    = w_upd ? (w_blank_calc ? 4'hF : w_digit) : bcd_out;

        w_an_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            w_an_nxt[i] = !((w_phase_nxt == S_SHOW) && !w_blank_nxt &&
                            (w_idx_nxt == C_IW'(i)));
        end

        w_fd_nxt  = (w_phase_nxt == S_SHOW) && (w_idx_nxt == C_IDX_LAST) &&
                    (w_cnt_nxt == C_SHOW_LAST);
        w_ack_nxt = w_boundary && (load || r_pending_vld);
    end

    // Value buffers and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active      <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
            r_code_vld    <= 1'b0;
            r_blank       <= 1'b0;
            bcd_out       <= 4'hF;
            an_n          <= '1;
            frame_done    <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            if (w_boundary) begin
                r_pending_vld <= 1'b0;
            end else if (load) begin
                r_pending     <= bcd_in;
                r_pending_vld <= 1'b1;
            end
            r_code_vld <= 1'b1;
            r_blank    <= w_blank_nxt;
            bcd_out    <= w_bcd_nxt;
            an_n       <= w_an_nxt;
            frame_done <= w_fd_nxt;
            load_ack   <= w_ack_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_scanner
// Brief    : Directed self-checking bench for bcd_display_scanner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, lzb_en;
    logic [15:0] bcd_in;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        frame_done, load_ack;

    logic        load1;
    logic [3:0]  bcd_in1;
    logic [3:0]  bcd_out1;
    logic [0:0]  an_n1;
    logic        frame_done1, load_ack1;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(.DIGITS(4), .SCAN_DIV(4), .GUARD(1)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .lzb_en(lzb_en),
        .bcd_out(bcd_out), .an_n(an_n), .frame_done(frame_done), .load_ack(load_ack)
    );

    bcd_display_scanner #(.DIGITS(1), .SCAN_DIV(1), .GUARD(0)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .bcd_in(bcd_in1), .lzb_en(1'b0),
        .bcd_out(bcd_out1), .an_n(an_n1), .frame_done(frame_done1), .load_ack(load_ack1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto(input int t);
        while (k < t) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load = 1'b0; bcd_in = '0; lzb_en = 1'b0;
        load1 = 1'b0; bcd_in1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an",   an_n, 4'hF);
        check("rst_bcd",  bcd_out, 4'hF);
        check("rst_fd",   frame_done, 0);
        check("rst_ack",  load_ack, 0);
        check("rst_an1",  an_n1, 1);
        rst = 1'b0;
        k = 0;

        // Idle frame, value 0
        check("f0_guard_an", an_n, 4'hF);
        goto(1);  check("f0_d0_an", an_n, 4'hE); check("f0_d0_bcd", bcd_out, 4'h0);
        goto(2);  check("s_an1", an_n1, 0); check("s_fd1", frame_done1, 1); check("s_bcd1", bcd_out1, 4'h0);
        goto(3);  load1 = 1'b1; bcd_in1 = 4'h7;
        goto(4);  load1 = 1'b0;
                  check("s_bcd1_load", bcd_out1, 4'h7); check("s_ack1", load_ack1, 1);
                  check("f0_d0_end_an", an_n, 4'hE);
        goto(5);  check("f0_g1_an", an_n, 4'hF); check("s_ack1_clr", load_ack1, 0);
                  bcd_in1 = 4'h9; load1 = 1'b1;
        goto(6);  load1 = 1'b0;
                  check("s_bcd1_load2", bcd_out1, 4'h9); check("s_fd1_b", frame_done1, 1);
                  check("f0_d1_an", an_n, 4'hD);
        goto(10); load = 1'b1; bcd_in = 16'h1234;
        goto(11); load = 1'b0;
                  check("f0_d2_an", an_n, 4'hB); check("f0_d2_bcd_old", bcd_out, 4'h0);
        goto(16); check("f0_d3_an", an_n, 4'h7);
        goto(18); check("f0_fd_early", frame_done, 0);
        goto(19); check("f0_fd", frame_done, 1);

        // Frame showing 1234
        goto(20); check("f1_ack", load_ack, 1); check("f1_g0_an", an_n, 4'hF);
                  check("f1_g0_bcd", bcd_out, 4'h4); check("f1_fd_clr", frame_done, 0);
        goto(21); check("f1_ack_clr", load_ack, 0);
                  check("f1_d0_an", an_n, 4'hE); check("f1_d0_bcd", bcd_out, 4'h4);
        goto(26); check("f1_d1_an", an_n, 4'hD); check("f1_d1_bcd", bcd_out, 4'h3);
        goto(31); check("f1_d2_an", an_n, 4'hB); check("f1_d2_bcd", bcd_out, 4'h2);
        goto(36); check("f1_d3_an", an_n, 4'h7); check("f1_d3_bcd", bcd_out, 4'h1);
        goto(39); check("f1_fd", frame_done, 1);
        goto(40); check("f2_no_ack", load_ack, 0);

        // Leading-zero blanking with 0050, then 0000
        goto(41); lzb_en = 1'b1; load = 1'b1; bcd_in = 16'h0050;
        goto(42); load = 1'b0;
        goto(60); check("f3_ack", load_ack, 1);
        goto(61); check("lz_d0_an", an_n, 4'hE); check("lz_d0_bcd", bcd_out, 4'h0);
        goto(62); load = 1'b1; bcd_in = 16'h0000;
        goto(63); load = 1'b0;
        goto(66); check("lz_d1_an", an_n, 4'hD); check("lz_d1_bcd", bcd_out, 4'h5);
        goto(71); check("lz_d2_an", an_n, 4'hF); check("lz_d2_bcd", bcd_out, 4'hF);
        goto(76); check("lz_d3_an", an_n, 4'hF); check("lz_d3_bcd", bcd_out, 4'hF);
        goto(79); check("lz_fd", frame_done, 1);
        goto(80); check("f4_ack", load_ack, 1);
        goto(81); check("z_d0_an", an_n, 4'hE); check("z_d0_bcd", bcd_out, 4'h0);

        // Overwritten pending loads, then a bypass load on the boundary
        goto(85); load = 1'b1; bcd_in = 16'h1111;
        goto(86); load = 1'b0;
                  check("z_d1_an", an_n, 4'hF); check("z_d1_bcd", bcd_out, 4'hF);
        goto(90); load = 1'b1; bcd_in = 16'h2222;
        goto(91); load = 1'b0;
        goto(99); check("ov_fd", frame_done, 1);
                  load = 1'b1; bcd_in = 16'h3333;
        goto(100); load = 1'b0; check("ov_ack", load_ack, 1);
        goto(101); check("ov_ack_single", load_ack, 0);
                   check("ov_d0_an", an_n, 4'hE); check("ov_d0_bcd", bcd_out, 4'h3);
        goto(105); load = 1'b1; bcd_in = 16'h9876; lzb_en = 1'b0;
        goto(106); load = 1'b0; check("ov_d1_bcd", bcd_out, 4'h3);
        goto(116); check("ov_d3_an", an_n, 4'h7); check("ov_d3_bcd", bcd_out, 4'h3);

        // 9876, then asynchronous reset during digit 2
        goto(120); check("f6_ack", load_ack, 1);
        goto(121); check("v_d0_bcd", bcd_out, 4'h6);
        goto(126); check("v_d1_bcd", bcd_out, 4'h7);
        goto(132); check("v_d2_an", an_n, 4'hB); check("v_d2_bcd", bcd_out, 4'h8);
        #2; rst = 1'b1;
        #1;
        check("ar_an", an_n, 4'hF); check("ar_bcd", bcd_out, 4'hF);
        check("ar_fd", frame_done, 0); check("ar_ack", load_ack, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        check("ar_g0_an", an_n, 4'hF);
        goto(1);  check("ar_d0_an", an_n, 4'hE); check("ar_d0_bcd", bcd_out, 4'h0);
        goto(16); check("ar_d3_an", an_n, 4'h7); check("ar_d3_bcd", bcd_out, 4'h0);
        goto(19); check("ar_fd", frame_done, 1);
        goto(20); check("ar_no_ack", load_ack, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Multiplexed-display scan stage directly upstream of the BCD-to-7-segment decoder.
- Holds a multi-digit packed BCD value and time-multiplexes one digit at a time onto a 4-bit BCD bus that feeds the decoder.
- Drives active-low digit-enable (anode) lines with a guard interval between digits to prevent ghosting.
- New values are double-buffered and applied only at frame boundaries so the display never tears; optional leading-zero blanking.

Parameters:
- DIGITS, 4, number of display digits (≥1); digit 0 is least significant.
- SCAN_DIV, 50000, clock cycles each digit is shown (≥1).
- GUARD, 2, clock cycles with all anodes off before each digit (≥0; 0 removes the guard phase).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  single-cycle request to accept bcd_in.
- bcd_in  input  4*DIGITS  packed BCD value; digit i at bits [4i+3:4i].
- lzb_en  input  1  leading-zero blanking enable, sampled every cycle.
- bcd_out  output  4  current digit code to the decoder; 4'hF means blank, which the decoder's default case renders as all segments off.
- an_n  output  DIGITS  active-low digit enables; at most one bit low at any time.
- frame_done  output  1  one-cycle pulse at the end of the last digit's show phase.
- load_ack  output  1  one-cycle pulse the cycle after a loaded value becomes active.

Behaviour:
- Reset (async assert, any time including mid-frame):
  - idx=0, phase=GUARD (SHOW if GUARD=0), cnt=0.
  - active=0, pending=0, pending_valid=0.
  - an_n all 1, bcd_out=4'hF, frame_done=0, load_ack=0.
  - Normal operation starts on the first clk edge after deassertion.
- Registers: active (displayed value), pending plus pending_valid, idx (0..DIGITS-1), cnt, phase {GUARD, SHOW}.
- GUARD phase:
  - an_n all 1; bcd_out already carries digit idx's code (setup time for the decoder).
  - After GUARD cycles, enter SHOW with cnt=0.
- SHOW phase:
  - an_n[idx]=0 unless digit idx is blanked; bcd_out holds digit idx's code.
  - After SCAN_DIV cycles, idx advances (DIGITS-1 wraps to 0), the next digit's code is registered onto bcd_out, and the block enters GUARD.
  - Per-digit period is GUARD+SCAN_DIV cycles; frame period is DIGITS*(GUARD+SCAN_DIV).
- Digit code for idx:
  - Code is active[4idx+3:4idx], passed through unchanged, including non-BCD codes A–F.
  - Blanked when lzb_en=1, idx>0, and every digit from idx up to DIGITS-1 in active equals 0.
  - A blanked digit gives bcd_out=4'hF and an_n all 1 during its SHOW; scan timing is unchanged.
  - Digit 0 is never blanked, so value 0 shows "0".
- Frame boundary is the last SHOW cycle of idx=DIGITS-1; frame_done=1 on that cycle only.
- Load and buffering:
  - load=1 off the boundary: pending<=bcd_in, pending_valid<=1. Repeated loads overwrite pending; last value wins.
  - At the boundary with load=0 and pending_valid=1: active<=pending, pending_valid<=0, load_ack=1 on the next cycle.
  - At the boundary with load=1: active<=bcd_in directly (bypass), pending_valid<=0, load_ack=1 on the next cycle. Any older pending value is discarded.
  - At the boundary with no pending value and no load: active is unchanged and load_ack stays 0.
- The new active value is first displayed starting with digit 0 of the next frame.
- lzb_en changes take effect at the next digit-code registration (start of the next GUARD).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (DIGITS=4, SCAN_DIV=4, GUARD=1, frame=20 cycles unless noted):
- Reset then idle -> an_n=4'b1111 and bcd_out=4'hF during reset. After release, the pattern repeats: 1 cycle an_n=1111, then 4 cycles an_n=1110 with bcd_out=0, then digits 1..3 the same way. frame_done pulses every 20 cycles.
- load with bcd_in=16'h1234 mid-frame -> display unchanged until the boundary. load_ack 1 cycle after frame_done. Next frame shows bcd_out 4,3,2,1 with an_n 1110, 1101, 1011, 0111.
- lzb_en=1, value 16'h0050 -> digit 0 shows 0 and digit 1 shows 5. Digits 2 and 3 have an_n=1111 and bcd_out=4'hF for their SHOW cycles. Value 16'h0000 shows only digit 0 = 0.
- Loads 16'h1111 then 16'h2222 in one frame, then load 16'h3333 on the boundary cycle -> active=16'h3333, a single load_ack, and 1111/2222 are never displayed.
- rst asserted during SHOW of digit 2 with active=16'h9876 -> outputs return to reset values immediately (asynchronously), active=0, and the scan restarts at digit 0 after release.
- Stress with DIGITS=1, GUARD=0, SCAN_DIV=1 -> an_n constantly 0, frame_done high every cycle, and a load appears on bcd_out within 2 cycles.
